// File: rtl/sr_latch_writer.sv
`default_nettype none
// ============================================================================
// Module      : sr_latch_writer
// Description : Write controller for a bank of WIDTH gated SR latches.
//               Accepts a masked write over valid/ready, sequences the latch
//               protocol (setup -> enable pulse -> hold -> clear), then reads
//               Q/QBAR back and reports done, readback data and an error flag.
//               S and R are derived from one data/mask pair so a bit can
//               never see S=R=1.
// Ports       : clk        - clock, all state on rising edge
//               rst        - synchronous active-high reset
//               wr_valid   - write request valid
//               wr_ready   - idle, able to accept a write
//               wr_data    - target latch values
//               wr_mask    - 1 = write bit, 0 = leave bit (S=R=0)
//               s, r, en   - set / reset / gate drives to the latch bank
//               latch_q    - latch Q readback
//               latch_qbar - latch QBAR readback
//               done       - one-cycle pulse at end of a write sequence
//               rd_data    - latch_q sampled in CHECK
//               err        - readback mismatch or Q/QBAR not complementary
// Revision    : 1.0 - initial release
// ============================================================================
module sr_latch_writer #(
    parameter int WIDTH     = 4,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] wr_mask,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    output logic             en,
    input  logic [WIDTH-1:0] latch_q,
    input  logic [WIDTH-1:0] latch_qbar,
    output logic             done,
    output logic [WIDTH-1:0] rd_data,
    output logic             err
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_PULSE = 3'd2;
    localparam logic [2:0] c_ST_HOLD  = 3'd3;
    localparam logic [2:0] c_ST_CLEAR = 3'd4;
    localparam logic [2:0] c_ST_CHECK = 3'd5;

    // One down-counter serves both the setup and pulse phases.
    localparam int c_CNT_MAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_SETUP_LOAD = c_CNT_W'(SETUP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_PULSE_LOAD = c_CNT_W'(PULSE_CYC - 1);

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   r_mask;
    logic [WIDTH-1:0]   r_shadow;
    logic               r_wr_ready;
    logic [WIDTH-1:0]   r_s;
    logic [WIDTH-1:0]   r_r;
    logic               r_en;
    logic               r_done;
    logic [WIDTH-1:0]   r_rd_data;
    logic               r_err;

    logic [WIDTH-1:0]   w_expected;
    logic               w_err;

    // Masked bits take the new data; unmasked bits keep the believed contents.
    assign w_expected = (r_data & r_mask) | (r_shadow & ~r_mask);
    // A healthy latch reads back the expected value with QBAR = ~Q.
    assign w_err      = (|(latch_q ^ w_expected)) | (|(~(latch_q ^ latch_qbar)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_data     <= '0;
            r_mask     <= '0;
            r_shadow   <= '0;
            r_wr_ready <= 1'b1;
            r_s        <= '0;
            r_r        <= '0;
            r_en       <= 1'b0;
            r_done     <= 1'b0;
            r_rd_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (wr_valid && r_wr_ready) begin
                        r_data     <= wr_data;
                        r_mask     <= wr_mask;
                        // S and R are disjoint by construction.
                        r_s        <= wr_data & wr_mask;
                        r_r        <= ~wr_data & wr_mask;
                        r_wr_ready <= 1'b0;
                        r_cnt      <= c_SETUP_LOAD;
                        r_state    <= c_ST_SETUP;
                    end
                end
                c_ST_SETUP: begin
                    if (r_cnt == '0) begin
                        r_en    <= 1'b1;
                        r_cnt   <= c_PULSE_LOAD;
                        r_state <= c_ST_PULSE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_ST_PULSE: begin
                    if (r_cnt == '0) begin
                        r_en    <= 1'b0;
                        r_state <= c_ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_ST_HOLD: begin
                    // S/R stay put through the cycle EN falls, then release.
                    r_s     <= '0;
                    r_r     <= '0;
                    r_state <= c_ST_CLEAR;
                end
                c_ST_CLEAR: begin
                    r_state <= c_ST_CHECK;
                end
                c_ST_CHECK: begin
                    r_rd_data  <= latch_q;
                    r_err      <= w_err;
                    r_done     <= 1'b1;
                    r_shadow   <= w_expected;
                    r_wr_ready <= 1'b1;
                    r_state    <= c_ST_IDLE;
                end
                default: begin
                    r_s        <= '0;
                    r_r        <= '0;
                    r_en       <= 1'b0;
                    r_wr_ready <= 1'b1;
                    r_state    <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign wr_ready = r_wr_ready;
    assign s        = r_s;
    assign r        = r_r;
    assign en       = r_en;
    assign done     = r_done;
    assign rd_data  = r_rd_data;
    assign err      = r_err;

endmodule
`default_nettype wire
